// File: rtl/conv_requant_buf.sv
// Per-channel requantizer and feature-map buffer: 32-bit signed PE results are rounded,
// ReLU'd and saturated to 8-bit pixels, then exposed through a 1-cycle read port.
// Optional high-clamp counter is enabled by defining CONV_SAT_COUNT_EN.
module conv_requant_buf #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int MAP_DIM = 13,
    parameter int SHIFT   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             done,
    input  logic [7:0]       rd_addr,
    output logic [OUT_W-1:0] rd_data
`ifdef CONV_SAT_COUNT_EN
    ,
    output logic [7:0]       sat_count
`endif
);
    localparam int DEPTH = MAP_DIM * MAP_DIM;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [IN_W:0] ROUND     = (IN_W + 1)'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [OUT_W-1:0]  mem [DEPTH];

    logic signed [IN_W:0] ext_sum;
    logic signed [IN_W:0] shifted;
    logic                 sat_hi;
    logic [OUT_W-1:0]     q_val;
    logic                 accept;

    // One extra bit of headroom so the rounding add cannot overflow.
    always_comb begin
        ext_sum = {in_data[IN_W-1], in_data} + ROUND;
        shifted = ext_sum >>> SHIFT;
        sat_hi  = !shifted[IN_W] && (shifted[IN_W-1:OUT_W] != '0);
        q_val   = shifted[IN_W] ? '0 : (sat_hi ? '1 : shifted[OUT_W-1:0]);
    end

    // A start in the same cycle takes priority and drops the sample.
    assign accept = in_valid && in_ready && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        wr_ptr   <= '0;
                    end
                end
                FILL: begin
                    if (start) begin
                        wr_ptr <= '0;
                    end else if (accept) begin
                        if (wr_ptr == LAST_ADDR) begin
                            wr_ptr   <= '0;
                            state    <= FULL;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        wr_ptr   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                    wr_ptr   <= '0;
                end
            endcase
        end
    end

    // Buffer contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= q_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr[AW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

`ifdef CONV_SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (start) begin
            sat_count <= '0;
        end else if (accept && sat_hi && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_requant_buf.sv
// Directed bench for conv_requant_buf: table-driven requantization vectors plus
// hand-written sequences for full maps, restart, async reset and ignored input.
module tb_conv_requant_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        done;
    logic [7:0]  rd_addr = '0;
    logic [7:0]  rd_data;
`ifdef CONV_SAT_COUNT_EN
    logic [7:0]  sat_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    conv_requant_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
`ifdef CONV_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic pulse_start(input logic with_valid, input logic [31:0] d);
        start    = 1'b1;
        in_valid = with_valid;
        in_data  = d;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        int ok;

        vecs[0]  = '{32'h0000_0180, 8'd2};
        vecs[1]  = '{32'h0000_017F, 8'd1};
        vecs[2]  = '{32'h0000_0080, 8'd1};
        vecs[3]  = '{32'hFFFF_FF00, 8'd0};
        vecs[4]  = '{32'h0001_0000, 8'd255};
        vecs[5]  = '{32'h7FFF_FFFF, 8'd255};
        vecs[6]  = '{32'h0000_0000, 8'd0};
        vecs[7]  = '{32'h0000_007F, 8'd0};
        vecs[8]  = '{32'h0000_00FF, 8'd1};
        vecs[9]  = '{32'hFFFF_FF80, 8'd0};
        vecs[10] = '{32'h0000_FF7F, 8'd255};
        vecs[11] = '{32'h0000_FF80, 8'd255};

        // Reset, checked before any clock edge releases it
        #23;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_done", done, 0);
        check("reset_rd_data", rd_data, 0);
`ifdef CONV_SAT_COUNT_EN
        check("reset_sat_count", sat_count, 0);
`endif
        tick();

        // Requantization table
        pulse_start(1'b0, 32'h0);
        check("fill_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) push(vecs[i].data);
        check("table_done_low", done, 0);
        for (int i = 0; i < 12; i++) begin
            rd(8'(i), r);
            $display("vec %0d: in=0x%08h q=%0d exp=%0d", i, vecs[i].data, r, vecs[i].exp);
            check($sformatf("q_vec%0d", i), r, vecs[i].exp);
        end
`ifdef CONV_SAT_COUNT_EN
        check("table_sat_count", sat_count, 3);
`endif

        // Full map with valid bubbles (start here restarts the fill)
        pulse_start(1'b0, 32'h0);
        for (int k = 0; k < 169; k++) begin
            if ($urandom_range(0, 1) == 1) tick();
            if (k == 168) check("map_done_before_last", done, 0);
            push(32'(k) << 8);
        end
        check("map_done", done, 1);
        check("map_in_ready_low", in_ready, 0);
        ok = 1;
        for (int k = 0; k < 169; k++) begin
            rd(8'(k), r);
            if (k == 0 || k == 168) check($sformatf("map_rd%0d", k), r, 32'(k));
            else if (r !== 8'(k)) ok = 0;
        end
        check("map_rd_all", ok, 1);
        $display("full map read back, all_ok=%0d", ok);
        rd(8'd200, r);
        check("map_rd_out_of_range", r, 0);
        push(32'h0000_5500);
        rd(8'd0, r);
        check("full_ignores_valid", r, 0);
        check("full_done_held", done, 1);
`ifdef CONV_SAT_COUNT_EN
        check("map_sat_count", sat_count, 0);
`endif

        // Restart mid-fill; the sample beside the second start must be dropped
        pulse_start(1'b0, 32'h0);
        check("restart_done_cleared", done, 0);
        for (int k = 0; k < 50; k++) push(32'h0000_1000);
        pulse_start(1'b1, 32'h0007_F000);
        for (int k = 0; k < 168; k++) push(32'h0000_0300);
        check("restart_done_at_168", done, 0);
        push(32'h0000_0300);
        check("restart_done_at_169", done, 1);
        ok = 1;
        for (int k = 0; k < 169; k++) begin
            rd(8'(k), r);
            if (r !== 8'd3) ok = 0;
        end
        check("restart_all_three", ok, 1);
        $display("restart map read back, all_ok=%0d", ok);
`ifdef CONV_SAT_COUNT_EN
        check("restart_sat_count", sat_count, 0);
`endif

        // Asynchronous reset between edges mid-fill
        pulse_start(1'b0, 32'h0);
        for (int k = 0; k < 100; k++) push(32'h0000_0500);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_in_ready", in_ready, 0);
        check("async_done", done, 0);
        check("async_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();
        push(32'h0000_5500);
        rd(8'd0, r);
        check("idle_ignores_valid", r, 5);
        check("idle_in_ready", in_ready, 0);
        pulse_start(1'b0, 32'h0);
        for (int k = 0; k < 168; k++) push(32'(k + 7) << 8);
        check("post_reset_done_at_168", done, 0);
        push(32'(175) << 8);
        check("post_reset_done_at_169", done, 1);
        rd(8'd0, r);
        check("post_reset_rd0", r, 7);
        rd(8'd168, r);
        check("post_reset_rd168", r, 175);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
